painel_passo: RTL and testbench
===============================

// Module: painel_passo
// PURPOSE
//   Board-input front end for the DE2 processor top level. Cleans the raw
//   push-button (KEY, active-low) and run switch and produces a one-cycle
//   step enable that advances the processor one instruction.
//   Two modes: manual single-step from the button, or free-running from a
//   prescaler. This is the input-side counterpart of the HEX/LEDR display
//   path. The step counter feeds LEDR for debug.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000    consecutive stable cycles needed to accept a new level (10 ms @ 50 MHz)
//   RUN_DIV          25000000  clock cycles between step pulses in run mode (2 Hz @ 50 MHz)
//   CNT_W            8         width of step_count
// PORTS
//   clock        in   1      board clock (CLOCK_50); the only clock
//   reset        in   1      asynchronous, active-low; 0 forces the reset state
//   btn_step_n   in   1      raw KEY input, 0 = pressed; asynchronous to clock
//   sw_run       in   1      raw switch: 1 = run mode, 0 = manual mode
//   halt         in   1      synchronous, from processor; 1 = suppress all step pulses
//   step_en      out  1      one-cycle pulse; processor advances on clock when 1
//   run_mode     out  1      debounced mode currently in effect
//   step_count   out  CNT_W  pulses issued since reset; saturates
// BEHAVIOUR
//   Reset (reset=0, async):
//     - step_en=0, run_mode=0, step_count=0
//     - debounce counters=0, prescaler=0
//     - debounced button level=1 (released), FSM=MANUAL
//   Synchronizer:
//     - btn_step_n and sw_run each pass through a 2-FF synchronizer before use
//   Debounce (one instance per input):
//     - counter clears whenever the synced input equals the current debounced level
//     - otherwise the counter increments
//     - at DEBOUNCE_CYCLES-1 the debounced level takes the synced value and the counter clears
//     - a glitch shorter than DEBOUNCE_CYCLES cycles never changes the level
//   Press event: debounced button level goes 1 -> 0, registered as a 1-cycle strobe.
//     - Release (0 -> 1) generates no event.
//     - Holding the button gives exactly one event (no auto-repeat).
//   FSM states MANUAL, RUN:
//     - MANUAL -> RUN when debounced sw_run=1; RUN -> MANUAL when it is 0
//     - run_mode=1 exactly in RUN
//     - The transition takes effect the cycle after the debounced level changes.
//     - On any transition the prescaler clears to 0.
//   MANUAL:
//     - step_en=1 for exactly the cycle after a press event, unless halt=1 in that cycle
//     - A suppressed press is dropped, not queued.
//   RUN:
//     - prescaler counts 0..RUN_DIV-1 and wraps to 0
//     - step_en=1 in the cycle after the prescaler is at RUN_DIV-1, if halt=0
//     - Button press events are ignored.
//     - halt=1 suppresses the pulse but the prescaler keeps counting.
//   Latency: button edge at pin -> step_en = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
//   step_en is never high on two consecutive cycles; with RUN_DIV=1 it pulses every other cycle.
//   step_count increments by 1 on each cycle step_en=1 and holds at 2^CNT_W-1.
//   Simultaneous mode change and prescaler terminal count: the mode change wins; no pulse that cycle.
//   Simultaneous press event and entry into RUN: the event is discarded.
//   Reset mid-debounce or mid-prescale: all progress is lost; a button held through
//   reset release is seen as a new press only after it is released, debounced, and pressed again.
// TESTING (bench params DEBOUNCE_CYCLES=4, RUN_DIV=8, CNT_W=4)
//   1. Reset pulse, inputs idle -> step_en=0, run_mode=0, step_count=0 throughout.
//   2. btn_step_n low for 20 cycles then high -> exactly one step_en pulse,
//      7 cycles after the falling edge; step_count=1.
//   3. btn_step_n low 3 cycles, high 5, low 2 (glitches) -> no step_en; step_count=0.
//   4. sw_run=1 held 100 cycles -> run_mode=1 after 7 cycles, then step_en every 8 cycles;
//      halt=1 for 16 of them -> 2 pulses missing, spacing unchanged afterwards.
//   5. Run mode held for 200 cycles -> step_count stops at 15, step_en still pulses.
//   6. Button held, reset asserted then released -> no pulse until release, debounce,
//      and a fresh press; the fresh press gives one pulse.

Source files
------------

// File: rtl/painel_passo_if.sv
// rtl/painel_passo_if.sv - board-side input/step bundle for the step panel
interface painel_passo_if #(
    parameter int CNT_W = 8
);
    logic             btn_step_n;
    logic             sw_run;
    logic             halt;
    logic             step_en;
    logic             run_mode;
    logic [CNT_W-1:0] step_count;

    modport master (
        output btn_step_n,
        output sw_run,
        output halt,
        input  step_en,
        input  run_mode,
        input  step_count
    );

    modport slave (
        input  btn_step_n,
        input  sw_run,
        input  halt,
        output step_en,
        output run_mode,
        output step_count
    );
endinterface

// File: rtl/painel_passo.sv
// rtl/painel_passo.sv - debounced KEY/switch front end issuing single-step or free-run step pulses
module painel_passo #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int RUN_DIV         = 25000000,
    parameter int CNT_W           = 8
) (
    input  logic          clock,
    input  logic          reset,
    painel_passo_if.slave io
);
    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int PW = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
    localparam logic [DW-1:0]    DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0]    PS_LAST = PW'(RUN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {S_MANUAL, S_RUN} state_t;

    logic [1:0]       r_btn_sync;
    logic [1:0]       r_sw_sync;
    logic [DW-1:0]    r_btn_cnt;
    logic [DW-1:0]    r_sw_cnt;
    logic             r_btn_lvl;
    logic             r_btn_lvl_q;
    logic             r_btn_armed;
    logic             r_press;
    logic             r_sw_lvl;
    logic [PW-1:0]    r_presc;
    logic             r_tick;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    state_t           w_state_nxt;

    logic w_btn_in;
    logic w_btn_diff;
    logic w_btn_arming;
    logic w_btn_count;
    logic w_btn_done;
    logic w_sw_in;
    logic w_sw_diff;
    logic w_sw_done;
    logic w_mode_change;
    logic w_run_hold;
    logic w_step;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_btn_sync <= 2'b11;
            r_sw_sync  <= 2'b00;
        end else begin
            r_btn_sync <= {r_btn_sync[0], io.btn_step_n};
            r_sw_sync  <= {r_sw_sync[0], io.sw_run};
        end
    end

    assign w_btn_in   = r_btn_sync[1];
    assign w_btn_diff = (w_btn_in != r_btn_lvl);
    // After reset the released level is only trusted once it has been seen stable,
    // so a key held through reset cannot masquerade as a fresh press.
    assign w_btn_arming = !r_btn_armed && w_btn_in && r_btn_lvl;
    assign w_btn_count  = w_btn_diff || w_btn_arming;
    assign w_btn_done   = w_btn_count && (r_btn_cnt == DB_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_btn_cnt   <= '0;
            r_btn_lvl   <= 1'b1;
            r_btn_lvl_q <= 1'b1;
            r_btn_armed <= 1'b0;
            r_press     <= 1'b0;
        end else begin
            if (!w_btn_count || w_btn_done) begin
                r_btn_cnt <= '0;
            end else begin
                r_btn_cnt <= r_btn_cnt + DW'(1);
            end
            if (w_btn_done && w_btn_diff) begin
                r_btn_lvl <= w_btn_in;
            end
            if (w_btn_done && w_btn_in) begin
                r_btn_armed <= 1'b1;
            end
            r_btn_lvl_q <= r_btn_lvl;
            r_press     <= r_btn_armed && r_btn_lvl_q && !r_btn_lvl;
        end
    end

    assign w_sw_in   = r_sw_sync[1];
    assign w_sw_diff = (w_sw_in != r_sw_lvl);
    assign w_sw_done = w_sw_diff && (r_sw_cnt == DB_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sw_cnt <= '0;
            r_sw_lvl <= 1'b0;
        end else begin
            if (!w_sw_diff || w_sw_done) begin
                r_sw_cnt <= '0;
            end else begin
                r_sw_cnt <= r_sw_cnt + DW'(1);
            end
            if (w_sw_done) begin
                r_sw_lvl <= w_sw_in;
            end
        end
    end

    assign w_mode_change = (r_state == S_MANUAL) ? r_sw_lvl : !r_sw_lvl;
    assign w_run_hold    = (r_state == S_RUN) && !w_mode_change;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_MANUAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pending mode change blocks any pulse, so press-on-entry and terminal
    // count on exit are both dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_step      = 1'b0;
        case (r_state)
            S_MANUAL: begin
                if (r_sw_lvl) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_step = r_press && !io.halt;
                end
            end
            S_RUN: begin
                if (!r_sw_lvl) begin
                    w_state_nxt = S_MANUAL;
                end else begin
                    w_step = r_tick && !io.halt;
                end
            end
            default: w_state_nxt = S_MANUAL;
        endcase
    end

    // The !r_tick term keeps pulses apart when RUN_DIV is 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
        end else begin
            if (!w_run_hold || (r_presc == PS_LAST)) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
            r_tick <= w_run_hold && (r_presc == PS_LAST) && !r_tick;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (w_step && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign io.step_en    = w_step;
    assign io.run_mode   = (r_state == S_RUN);
    assign io.step_count = r_cnt;
endmodule

// File: tb/tb_painel_passo.sv
// tb/tb_painel_passo.sv - scoreboard bench for painel_passo with DEBOUNCE_CYCLES=4, RUN_DIV=8, CNT_W=4
module tb_painel_passo;
    localparam int DB  = 4;
    localparam int DIV = 8;
    localparam int CW  = 4;
    localparam int CAP = (1 << CW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    painel_passo_if #(.CNT_W(CW)) io();

    painel_passo #(
        .DEBOUNCE_CYCLES(DB),
        .RUN_DIV        (DIV),
        .CNT_W          (CW)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .io   (io.slave)
    );

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q[$];
    int   exp_cnt = 0;
    int   mon_t;
    logic prev_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int t);
        exp_q.push_back(t);
        if (exp_cnt < CAP) exp_cnt++;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected run-mode pulses: first RUN cycle is c+7 with prescaler 0, so
    // terminal count at c+14 and pulses at c+15+8k until the exit change.
    task automatic expect_run(input int c, input int last, input int h_lo, input int h_hi);
        for (int k = 0; c + 15 + DIV * k <= last; k++) begin
            if (!((c + 15 + DIV * k >= h_lo) && (c + 15 + DIV * k <= h_hi)))
                expect_pulse(c + 15 + DIV * k);
        end
    endtask

    always @(negedge clk) begin
        if (io.step_en === 1'b1) begin
            chk("back_to_back", {31'b0, prev_en}, 0);
            if (exp_q.size() > 0) begin
                mon_t = exp_q.pop_front();
                chk("pulse_cycle", cyc, mon_t);
            end else begin
                chk("spurious_step", {31'b0, io.step_en}, 0);
            end
        end
        prev_en <= io.step_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        io.btn_step_n = 1'b1;
        io.sw_run     = 1'b0;
        io.halt       = 1'b0;

        // 1: reset with idle inputs
        tick(3);
        chk("rst_step_en", {31'b0, io.step_en}, 0);
        chk("rst_run_mode", {31'b0, io.run_mode}, 0);
        chk("rst_step_count", {28'b0, io.step_count}, 0);
        rst_n = 1'b1;
        tick(12);
        chk("idle_run_mode", {31'b0, io.run_mode}, 0);
        chk("idle_step_count", {28'b0, io.step_count}, 0);

        // 2: clean press, one pulse 7 cycles after the edge
        c = cyc;
        io.btn_step_n = 1'b0;
        expect_pulse(c + 7);
        tick(20);
        io.btn_step_n = 1'b1;
        tick(20);
        chk("t2_missed", exp_q.size(), 0);
        chk("t2_step_count", {28'b0, io.step_count}, exp_cnt);

        // 3: glitches shorter than the debounce window
        io.btn_step_n = 1'b0; tick(3);
        io.btn_step_n = 1'b1; tick(5);
        io.btn_step_n = 1'b0; tick(2);
        io.btn_step_n = 1'b1; tick(20);
        chk("t3_step_count", {28'b0, io.step_count}, exp_cnt);

        // 4: run mode 100 cycles, halt over cycles c+40..c+55
        c = cyc;
        io.sw_run = 1'b1;
        expect_run(c, c + 105, c + 40, c + 55);
        tick(6);
        chk("t4_run_mode_early", {31'b0, io.run_mode}, 0);
        tick(1);
        chk("t4_run_mode_on", {31'b0, io.run_mode}, 1);
        tick(33);
        io.halt = 1'b1;
        tick(16);
        io.halt = 1'b0;
        tick(44);
        io.sw_run = 1'b0;
        tick(20);
        chk("t4_run_mode_off", {31'b0, io.run_mode}, 0);
        chk("t4_missed", exp_q.size(), 0);
        chk("t4_step_count", {28'b0, io.step_count}, exp_cnt);

        // 5: long run, counter saturates while pulses continue
        c = cyc;
        io.sw_run = 1'b1;
        expect_run(c, c + 205, -1, -1);
        tick(200);
        chk("t5_run_mode", {31'b0, io.run_mode}, 1);
        io.sw_run = 1'b0;
        tick(20);
        chk("t5_missed", exp_q.size(), 0);
        chk("t5_step_count_sat", {28'b0, io.step_count}, exp_cnt);

        // 6: key held through reset needs release and a fresh press
        c = cyc;
        io.btn_step_n = 1'b0;
        expect_pulse(c + 7);
        tick(20);
        chk("t6_pre_missed", exp_q.size(), 0);
        rst_n = 1'b0;
        exp_cnt = 0;
        tick(3);
        chk("t6_rst_step_count", {28'b0, io.step_count}, 0);
        chk("t6_rst_run_mode", {31'b0, io.run_mode}, 0);
        rst_n = 1'b1;
        tick(30);
        chk("t6_held_step_count", {28'b0, io.step_count}, 0);
        io.btn_step_n = 1'b1;
        tick(20);
        c = cyc;
        io.btn_step_n = 1'b0;
        expect_pulse(c + 7);
        tick(20);
        io.btn_step_n = 1'b1;
        tick(20);
        chk("t6_missed", exp_q.size(), 0);
        chk("t6_step_count", {28'b0, io.step_count}, exp_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
